// File: rtl/apb_reg_responder_pkg.sv
// Shared APB bus widths, FSM state type and register-index helper.
package apb_reg_responder_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_SEL_W  = 16;

    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_state_e;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/apb_reg_responder_wait_ctr.sv
// Loadable wait-state down-counter; zero drives PREADY, fire flags the edge raising it.
module apb_reg_responder_wait_ctr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    input  logic         clr,
    output logic         zero,
    output logic         fire
);

    logic [W-1:0] cnt;

    assign fire = load ? (load_val == '0) : (dec && cnt == W'(1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            zero <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (dec && cnt != '0) begin
            cnt  <= cnt - W'(1);
            zero <= (cnt == W'(1));
        end
    end

endmodule

// File: rtl/apb_reg_responder.sv
// APB3 register completer: RW register bank plus one read-only status word,
// with programmable wait states, decode errors and protocol-violation flags.
module apb_reg_responder
    import apb_reg_responder_pkg::*;
#(
    parameter int          SLV_IDX     = 0,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_CYCLES = 1,
    parameter int          ADDR_LSB    = 2,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [APB_ADDR_W-1:0]    PADDR,
    input  logic [APB_SEL_W-1:0]     PSEL,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [APB_DATA_W-1:0]    PWDATA,
    output logic [APB_DATA_W-1:0]    PRDATA,
    output logic                     PREADY,
    input  logic [APB_DATA_W-1:0]    status_in,
    output logic [NUM_REGS*32-1:0]   regs_out,
    output logic [NUM_REGS-1:0]      wr_pulse,
    output logic                     dec_err,
    output logic                     prot_err
);

    localparam int IW   = idx_w(NUM_REGS);
    localparam int LAST = NUM_REGS - 1;
    localparam logic [APB_ADDR_W-1:0] ONE  = APB_ADDR_W'(1);
    localparam logic [APB_ADDR_W-1:0] LO_M = (ONE << ADDR_LSB) - ONE;
    localparam logic [APB_ADDR_W-1:0] HI_M = ~((ONE << (ADDR_LSB + IW)) - ONE);

    apb_state_e state_q, state_d;

    logic [APB_ADDR_W-1:0] addr_q;
    logic                  wr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_DATA_W-1:0] regs [NUM_REGS-1];

    logic                  sel;
    logic                  setup, complete, abort, step, viol;
    logic                  fire;
    logic [APB_ADDR_W-1:0] addr_use;
    logic                  wr_use;
    logic [IW-1:0]         idx;
    logic                  legal, is_stat;
    logic [APB_DATA_W-1:0] rd_val;
    logic                  unused_psel;

    assign sel         = PSEL[SLV_IDX];
    assign unused_psel = ^PSEL;

    // Setup-edge decode sees the live bus; later edges use the captured copy.
    assign addr_use = (state_q == APB_IDLE) ? PADDR  : addr_q;
    assign wr_use   = (state_q == APB_IDLE) ? PWRITE : wr_q;
    assign idx      = addr_use[ADDR_LSB +: IW];
    assign legal    = ((addr_use & LO_M) == '0) && ((addr_use & HI_M) == '0);
    assign is_stat  = (idx == IW'(LAST));

    always_comb begin
        rd_val = '0;
        if (legal) rd_val = is_stat ? status_in : regs[idx];
    end

    always_comb begin
        state_d  = state_q;
        setup    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        step     = 1'b0;
        viol     = 1'b0;
        unique case (state_q)
            APB_IDLE: begin
                if (sel && !PENABLE) begin
                    setup   = 1'b1;
                    state_d = APB_ACCESS;
                end else if (sel && PENABLE) begin
                    viol = 1'b1;
                end
            end
            APB_ACCESS: begin
                if (!sel) begin
                    abort   = 1'b1;
                    viol    = 1'b1;
                    state_d = APB_IDLE;
                end else begin
                    if (PADDR != addr_q || PWRITE != wr_q) viol = 1'b1;
                    if (PREADY) begin
                        complete = 1'b1;
                        state_d  = APB_IDLE;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    apb_reg_responder_wait_ctr #(.W(4)) u_wait (
        .clk      (PCLK),
        .rst      (PRESET),
        .load     (setup),
        .load_val (4'(WAIT_CYCLES)),
        .dec      (step),
        .clr      (complete || abort),
        .zero     (PREADY),
        .fire     (fire)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= APB_IDLE;
            addr_q   <= '0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            PRDATA   <= '0;
            wr_pulse <= '0;
            dec_err  <= 1'b0;
            prot_err <= 1'b0;
            for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= RESET_VAL;
        end else begin
            state_q  <= state_d;
            wr_pulse <= '0;
            prot_err <= viol;
            dec_err  <= complete && !legal;
            PRDATA   <= (fire && !wr_use) ? rd_val : '0;
            if (setup) begin
                addr_q  <= PADDR;
                wr_q    <= PWRITE;
                wdata_q <= PWDATA;
            end
            if (complete && wr_q && legal && !is_stat) begin
                regs[idx]     <= wdata_q;
                wr_pulse[idx] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_out
        assign regs_out[i*32 +: 32] = regs[i];
    end
    assign regs_out[LAST*32 +: 32] = '0;

endmodule

// File: tb/tb_apb_reg_responder.sv
// Directed bench: DUT a has one wait state, DUT b has none (back-to-back test).
module tb_apb_reg_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  paddr;
    logic [15:0]  psel_a, psel_b;
    logic         penable, pwrite;
    logic [31:0]  pwdata;
    logic [31:0]  status_a, status_b;

    logic [31:0]  prdata_a, prdata_b;
    logic         pready_a, pready_b;
    logic [255:0] regs_a, regs_b;
    logic [7:0]   wrp_a, wrp_b;
    logic         dec_a, dec_b, prot_a, prot_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_reg_responder #(.SLV_IDX(0), .NUM_REGS(8), .WAIT_CYCLES(1)) dut_a (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel_a),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata_a), .PREADY(pready_a), .status_in(status_a),
        .regs_out(regs_a), .wr_pulse(wrp_a), .dec_err(dec_a),
        .prot_err(prot_a)
    );

    apb_reg_responder #(.SLV_IDX(0), .NUM_REGS(8), .WAIT_CYCLES(0)) dut_b (
        .PCLK(clk), .PRESET(rst), .PADDR(paddr), .PSEL(psel_b),
        .PENABLE(penable), .PWRITE(pwrite), .PWDATA(pwdata),
        .PRDATA(prdata_b), .PREADY(pready_b), .status_in(status_b),
        .regs_out(regs_b), .wr_pulse(wrp_b), .dec_err(dec_b),
        .prot_err(prot_b)
    );

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        psel_a  = '0;
        psel_b  = '0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    // Returns at the negedge of the PREADY=1 cycle, bus still driven.
    task automatic xfer(input bit b, input logic [31:0] a, input bit w,
                        input logic [31:0] d, output logic [31:0] rd,
                        output int cyc);
        @(negedge clk);
        psel_a  = b ? 16'h0 : 16'h1;
        psel_b  = b ? 16'h1 : 16'h0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        penable = 1'b0;
        cyc     = 1;
        @(negedge clk);
        penable = 1'b1;
        cyc++;
        while (!(b ? pready_b : pready_a) && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        rd = b ? prdata_b : prdata_a;
    endtask

    logic [31:0]  rd;
    int           cyc;
    logic [255:0] img;

    initial begin
        rst      = 1'b1;
        paddr    = 32'h4;
        psel_a   = 16'h1;
        psel_b   = 16'h1;
        penable  = 1'b0;
        pwrite   = 1'b1;
        pwdata   = 32'hDEAD_BEEF;
        status_a = 32'h0;
        status_b = 32'h0;

        // 1. reset with traffic on the bus
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pready", 256'(pready_a), 256'(0));
        chk("rst_prdata", 256'(prdata_a), 256'(0));
        chk("rst_regs", regs_a, '0);
        chk("rst_prot", 256'(prot_a), 256'(0));
        rst = 1'b0;
        idle();

        // 2. write then read back, one wait state
        xfer(0, 32'h4, 1, 32'hA5A5_0001, rd, cyc);
        chk("wr_cycles", 256'(cyc), 256'(3));
        idle();
        chk("wr_pulse1", 256'(wrp_a), 256'(8'b0000_0010));
        chk("wr_reg1", 256'(regs_a[63:32]), 256'(32'hA5A5_0001));
        xfer(0, 32'h4, 0, 32'h0, rd, cyc);
        chk("rd_reg1", 256'(rd), 256'(32'hA5A5_0001));
        chk("rd_cycles", 256'(cyc), 256'(3));
        idle();
        chk("prdata_idle", 256'(prdata_a), 256'(0));

        // 3. status register
        status_a = 32'hCAFE_F00D;
        xfer(0, 32'h1C, 0, 32'h0, rd, cyc);
        chk("rd_status", 256'(rd), 256'(32'hCAFE_F00D));
        idle();
        xfer(0, 32'h1C, 1, 32'h1234_5678, rd, cyc);
        idle();
        chk("st_no_pulse", 256'(wrp_a), 256'(0));
        chk("st_no_err", 256'(dec_a), 256'(0));
        chk("st_slice", 256'(regs_a[255:224]), 256'(0));

        // 4. decode errors
        img = '0;
        img[63:32] = 32'hA5A5_0001;
        xfer(0, 32'h20, 1, 32'hFFFF_FFFF, rd, cyc);
        chk("de_wr_cycles", 256'(cyc), 256'(3));
        idle();
        chk("de_wr_err", 256'(dec_a), 256'(1));
        chk("de_wr_pulse", 256'(wrp_a), 256'(0));
        chk("de_wr_regs", regs_a, img);
        xfer(0, 32'h5, 0, 32'h0, rd, cyc);
        chk("de_rd_data", 256'(rd), 256'(0));
        idle();
        chk("de_rd_err", 256'(dec_a), 256'(1));
        chk("de_rd_regs", regs_a, img);

        // 5a. PENABLE high from IDLE
        @(negedge clk);
        psel_a  = 16'h1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'h9;
        @(negedge clk);
        chk("ien_prot", 256'(prot_a), 256'(1));
        chk("ien_ready", 256'(pready_a), 256'(0));
        idle();
        chk("ien_regs", regs_a, img);

        // 5b. abort by dropping PSEL in ACCESS
        @(negedge clk);
        psel_a  = 16'h1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'h77;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel_a  = 16'h0;
        @(negedge clk);
        chk("ab_prot", 256'(prot_a), 256'(1));
        chk("ab_ready", 256'(pready_a), 256'(0));
        chk("ab_pulse", 256'(wrp_a), 256'(0));
        chk("ab_regs", regs_a, img);
        idle();

        // 5c. reset during the wait cycle
        @(negedge clk);
        psel_a  = 16'h1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h8;
        pwdata  = 32'h55;
        @(negedge clk);
        penable = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        chk("mr_ready", 256'(pready_a), 256'(0));
        rst    = 1'b0;
        psel_a = 16'h0;
        @(negedge clk);
        chk("mr_ready2", 256'(pready_a), 256'(0));
        chk("mr_pulse", 256'(wrp_a), 256'(0));
        chk("mr_reg2", 256'(regs_a[95:64]), 256'(0));
        idle();

        // 6. back-to-back writes, no wait states
        for (int i = 0; i < 4; i++) begin
            xfer(1, 32'(i * 4), 1, 32'h10 + 32'(i), rd, cyc);
            chk("b2b_cycles", 256'(cyc), 256'(2));
        end
        idle();
        chk("b2b_pulse3", 256'(wrp_b), 256'(8'b0000_1000));
        img = '0;
        img[31:0]   = 32'h10;
        img[63:32]  = 32'h11;
        img[95:64]  = 32'h12;
        img[127:96] = 32'h13;
        chk("b2b_regs", regs_b, img);
        xfer(1, 32'h8, 0, 32'h0, rd, cyc);
        chk("b2b_rd", 256'(rd), 256'(32'h12));
        chk("b2b_rd_cyc", 256'(cyc), 256'(2));

        // neighbouring select bit must be ignored
        @(negedge clk);
        psel_b  = 16'h2;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'h0;
        pwdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        penable = 1'b1;
        chk("nb_ready1", 256'(pready_b), 256'(0));
        @(negedge clk);
        chk("nb_ready2", 256'(pready_b), 256'(0));
        idle();
        chk("nb_pulse", 256'(wrp_b), 256'(0));
        chk("nb_regs", regs_b, img);
        chk("nb_prot", 256'(prot_b), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
